// File: rtl/nor16_zero_detect.sv
// 16-bit zero detector built as a two-level gate tree: four 4-input NORs (one per
// nibble) feeding a 4-input AND, plus a registered copy of the result for flag pipelines.
`timescale 1ns/10ps

module nor16_zero_detect #(
  parameter real DELAY = 0.05,
  parameter int  WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic [3:0]       nibble_zero,
  output logic             out_q
);

  // Level 1: each NOR flags an all-zero nibble after one gate delay.
  for (genvar k = 0; k < 4; k++) begin : g_nibble
    nor #(DELAY) u_nor (nibble_zero[k], in[4*k], in[4*k+1], in[4*k+2], in[4*k+3]);
  end

  // Level 2: the whole word is zero only when every nibble is zero.
  and #(DELAY) u_and (out, nibble_zero[0], nibble_zero[1], nibble_zero[2], nibble_zero[3]);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_nor16_zero_detect.sv
// Directed and swept checks of the 16-bit zero detector: reset, boundaries, walking one,
// gate-tree timing, mid-run reset and a random sweep against a reference model.
`timescale 1ns/10ps

module tb_nor16_zero_detect;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        out;
  logic [3:0]  nibble_zero;
  logic        out_q;

  int tests_run;
  int tests_failed;

  nor16_zero_detect dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .out         (out),
    .nibble_zero (nibble_zero),
    .out_q       (out_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] model_nibbles(input logic [15:0] v);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (v[4*k +: 4] == 4'h0);
    return r;
  endfunction

  task automatic check_comb(input string name, input logic exp_out, input logic [3:0] exp_nib);
    tests_run++;
    if (out !== exp_out) begin
      tests_failed++;
      $display("FAIL %s out: got %b expected %b (in=%h)", name, out, exp_out, in);
    end
    tests_run++;
    if (nibble_zero !== exp_nib) begin
      tests_failed++;
      $display("FAIL %s nibble_zero: got %b expected %b (in=%h)", name, nibble_zero, exp_nib, in);
    end
  endtask

  task automatic check_q(input string name, input logic exp_q);
    tests_run++;
    if (out_q !== exp_q) begin
      tests_failed++;
      $display("FAIL %s out_q: got %b expected %b (in=%h)", name, out_q, exp_q, in);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    in    = 16'h0000;
    @(posedge clk); #1;
    check_q("reset_initial", 1'b0);
  endtask

  task automatic test_all_zero();
    @(negedge clk);
    reset = 1'b0;
    in    = 16'h0000;
    #1;
    check_comb("all_zero", 1'b1, 4'b1111);
    @(posedge clk); #1;
    check_q("all_zero_q", 1'b1);
  endtask

  task automatic test_low_bits();
    @(negedge clk);
    in = 16'h0001;
    #1;
    check_comb("in_0001", 1'b0, 4'b1110);
    @(posedge clk); #1;
    check_q("in_0001_q", 1'b0);
    @(negedge clk);
    in = 16'h0002;
    #1;
    check_comb("in_0002", 1'b0, 4'b1110);
  endtask

  task automatic test_walking_one();
    logic [3:0] exp_nib;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in = 16'h0001 << i;
      exp_nib = 4'b1111;
      exp_nib[i/4] = 1'b0;
      #1;
      check_comb($sformatf("walk_%0d", i), 1'b0, exp_nib);
    end
    @(negedge clk);
    in = 16'hFFFF;
    #1;
    check_comb("all_ones", 1'b0, 4'b0000);
  endtask

  task automatic test_timing();
    @(negedge clk);
    in = 16'h0000;
    #1;
    check_comb("timing_start", 1'b1, 4'b1111);
    in = 16'h8000;
    #0.04;
    check_comb("timing_0p04", 1'b1, 4'b1111);
    #0.02;
    check_comb("timing_0p06", 1'b1, 4'b0111);
    #0.03;
    check_comb("timing_0p09", 1'b1, 4'b0111);
    #0.02;
    check_comb("timing_0p11", 1'b0, 4'b0111);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in = 16'h0000;
    @(posedge clk); #1;
    check_q("pre_reset_q", 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_q("mid_reset_q", 1'b0);
    check_comb("mid_reset_comb", 1'b1, 4'b1111);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_q("post_reset_q", 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0:       v = 16'h0000;
        1:       v = 16'h0001 << $urandom_range(0, 15);
        2:       v = 16'(4'($urandom_range(1, 15))) << (4 * $urandom_range(0, 3));
        default: v = 16'($urandom_range(0, 65535));
      endcase
      in = v;
      #1;
      check_comb("random", v == 16'h0000, model_nibbles(v));
      @(posedge clk); #1;
      check_q("random_q", v == 16'h0000);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    in           = 16'h0000;
    test_reset();
    test_all_zero();
    test_low_bits();
    test_walking_one();
    test_timing();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nor16_zero_detect.md
Name: nor16_zero_detect

Overview:
- 16-input NOR / zero detector: asserts when all 16 input bits are 0.
- One of four slices used by the ALU fast zero-flag logic. The 64-bit result is split into 16-bit groups, and the group outputs are ANDed to form the zero flag.
- Gate-level structure, two logic levels, per-gate propagation delay.
- Provides a combinational output plus a registered copy for pipelined flag use.

Parameters:
- DELAY, 0.05, propagation delay in ns applied to every gate primitive in the tree (timescale 1ns/10ps).
- WIDTH, 16, input width. Fixed at 16. Any other value is unsupported.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset. Affects only registered outputs.
- in  input  16  bits to test.
- out  output  1  combinational NOR of in: 1 iff in == 16'h0000.
- nibble_zero  output  4  combinational per-nibble zero flags. Bit k = 1 iff in[4k+3:4k] == 4'h0.
- out_q  output  1  out registered on rising clk.

Behaviour:
- Structure is fixed and built from gate primitives only, with no behavioural reduction operators.
  - Level 1: four 4-input NOR gates, gate k on in[4k+3:4k], producing nibble_zero[k].
  - Level 2: one 4-input AND of nibble_zero[3:0], producing out.
- Every gate carries #DELAY.
  - nibble_zero settles DELAY after the last input change.
  - out settles 2*DELAY (0.1 ns default) after the last input change.
- out and nibble_zero are purely combinational and are not affected by clk or reset.
- out_q, on each rising clk edge:
  - if reset == 1, out_q <= 0;
  - else out_q <= out.
  - Latency is one cycle from the in sample to out_q.
- Reset value: out_q = 0. There is no asynchronous path. If reset is asserted mid-operation, out_q clears at the next rising edge regardless of in.
- Before the first clock edge with reset high, out_q is X. Benches must apply reset for at least 1 cycle.
- Any X/Z on an input bit propagates per gate-primitive semantics. In particular, an X on any bit of a nibble whose other bits are 0 yields X on that nibble_zero and on out. A known 1 anywhere forces out = 0.
- Boundaries:
  - all zeros gives out = 1 and nibble_zero = 4'hF;
  - all ones gives out = 0 and nibble_zero = 4'h0;
  - a single set bit clears exactly one nibble_zero bit and out.

Test Plan:
- in = 16'h0000, wait 1 ns -> out = 1, nibble_zero = 4'b1111. After the next rising clk with reset = 0 -> out_q = 1.
- in = 16'h0001 -> out = 0, nibble_zero = 4'b1110. Then in = 16'h0002 -> out = 0, nibble_zero = 4'b1110.
- Walking one: in = 1<<i for i = 0..15 -> out = 0 and nibble_zero[i/4] = 0, other nibble flags = 1. Also in = 16'hFFFF -> out = 0, nibble_zero = 4'b0000.
- Timing: change in from 16'h0000 to 16'h8000 -> out is still 1 at +0.09 ns and 0 by +0.11 ns.
- Reset: in = 16'h0000 with out_q = 1; assert reset for one edge -> out_q = 0 after that edge. Deassert reset -> out_q = 1 after the next edge.
- Random sweep: 1000 random in values, each checked against the model out == (in == 0) and out_q == previous-cycle out.
